// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
// ILLEGAL_TRAP_EN adds the HALT state used by the illegal-instruction trap.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecute,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StAluWb,
        StBranch,
        StJump
`ifdef ILLEGAL_TRAP_EN
        , StHalt
`endif
    } state_e;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSll   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluSlt   = 4'd8;
    localparam logic [3:0] AluSltu  = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcTarget = 2'b01;
    localparam logic [1:0] PcAlu    = 2'b10;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    function automatic logic [2:0] imm_sel(logic [6:0] op);
        case (op)
            OpStore:         return ImmS;
            OpBranch:        return ImmB;
            OpLui, OpAuipc:  return ImmU;
            OpJal:           return ImmJ;
            default:         return ImmI;
        endcase
    endfunction

    function automatic logic instr_legal(logic [6:0] op, logic [2:0] funct3);
        case (op)
            OpReg, OpImm, OpLui, OpAuipc, OpJal: return 1'b1;
            OpLoad:   return !(funct3 inside {3'b011, 3'b110, 3'b111});
            OpStore:  return funct3[2] == 1'b0 && funct3[1:0] != 2'b11;
            OpBranch: return !(funct3 inside {3'b010, 3'b011});
            OpJalr:   return funct3 == 3'b000;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch handshake plus datapath strobes/selects between the sequencer and the datapath.
// ILLEGAL_TRAP_EN adds the sticky IllegalInstr flag.
interface multicycle_ctrl_if;
    logic        InstrReq;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        Zero;
    logic        signedLess;
    logic        unsignedLess;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic        LoadSign;
    logic [1:0]  SizeSrc;
    logic        InstrDone;
`ifdef ILLEGAL_TRAP_EN
    logic        IllegalInstr;
`endif

    modport master (
        input  InstrValid, Instr, Zero, signedLess, unsignedLess,
        output InstrReq, IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
        output ALUControl, ResultSrc, ImmSrc, LoadSign, SizeSrc, InstrDone
`ifdef ILLEGAL_TRAP_EN
        , output IllegalInstr
`endif
    );

    modport slave (
        output InstrValid, Instr, Zero, signedLess, unsignedLess,
        input  InstrReq, IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
        input  ALUControl, ResultSrc, ImmSrc, LoadSign, SizeSrc, InstrDone
`ifdef ILLEGAL_TRAP_EN
        , input IllegalInstr
`endif
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational op/funct3/funct7b5 to ALUControl mapping.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);
    always_comb begin
        alu_control = AluAdd;
        if (op == OpReg || op == OpImm) begin
            unique case (funct3)
                // Only register-register ops use bit 30 as SUB; ADDI immediates may set it.
                3'b000: alu_control = (op == OpReg && funct7b5) ? AluSub : AluAdd;
                3'b001: alu_control = AluSll;
                3'b010: alu_control = AluSlt;
                3'b011: alu_control = AluSltu;
                3'b100: alu_control = AluXor;
                3'b101: alu_control = funct7b5 ? AluSra : AluSrl;
                3'b110: alu_control = AluOr;
                3'b111: alu_control = AluAnd;
            endcase
        end else if (op == OpLui) begin
            alu_control = AluPassB;
        end else if (op == OpBranch) begin
            alu_control = AluSub;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: steps fetch/decode/execute/memory/writeback, owns PC update.
// Define ILLEGAL_TRAP_EN to trap illegal instructions into HALT with a sticky IllegalInstr.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned RESET_WAIT = 0
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    state_e      state_q, state_d;
    logic [6:0]  op_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q;
    logic [31:0] wait_q, wait_d;
    logic [3:0]  alu_ctrl;
    logic        fetch_req, capture, taken, dp_active, mem_active;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    alu_decoder u_alu_decoder (
        .op          (op_q),
        .funct3      (funct3_q),
        .funct7b5    (funct7b5_q),
        .alu_control (alu_ctrl)
    );

    assign fetch_req  = (state_q == StFetch) && (wait_q == '0);
    assign capture    = fetch_req && bus.InstrValid;
    assign dp_active  = state_q inside {StExecute, StAluWb, StMemAdr, StMemRead, StMemWb,
                                        StMemWrite, StBranch, StJump};
    assign mem_active = state_q inside {StMemAdr, StMemRead, StMemWb, StMemWrite};

    // Flags are produced by the SUB issued in BRANCH itself, so resolution is combinational.
    always_comb begin
        case (funct3_q)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = !bus.Zero;
            3'b100:  taken = bus.signedLess;
            3'b101:  taken = !bus.signedLess;
            3'b110:  taken = bus.unsignedLess;
            3'b111:  taken = !bus.unsignedLess;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            op_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            wait_q     <= RESET_WAIT;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
            if (capture) begin
                op_q       <= bus.Instr[6:0];
                funct3_q   <= bus.Instr[14:12];
                funct7b5_q <= bus.Instr[30];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        bus.InstrReq   = fetch_req;
        bus.IRWrite    = capture;
        bus.PCWrite    = 1'b0;
        bus.PCSrc      = PcPlus4;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 1'b0;
        bus.ALUControl = AluAdd;
        bus.ResultSrc  = ResAlu;
        bus.ImmSrc     = ImmI;
        bus.LoadSign   = 1'b0;
        bus.SizeSrc    = 2'b00;
        bus.InstrDone  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d      = illegal_q;
        bus.IllegalInstr = illegal_q;
`endif
        // ALU operands stay stable from EXECUTE/MEMADR through the final state.
        if (dp_active) begin
            bus.ALUSrcA    = (op_q == OpAuipc);
            bus.ALUSrcB    = op_q inside {OpImm, OpLui, OpAuipc, OpLoad, OpStore, OpJalr};
            bus.ALUControl = alu_ctrl;
        end
        if (dp_active || state_q == StDecode) bus.ImmSrc = imm_sel(op_q);
        if (mem_active) begin
            bus.SizeSrc  = funct3_q[1:0];
            bus.LoadSign = ~funct3_q[2];
        end

        case (state_q)
            StFetch: begin
                if (wait_q != '0) wait_d = wait_q - 32'd1;
                if (capture) state_d = StDecode;
            end
            StDecode: begin
`ifdef ILLEGAL_TRAP_EN
                if (!instr_legal(op_q, funct3_q)) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else
`endif
                case (op_q)
                    OpReg, OpImm, OpLui, OpAuipc: state_d = StExecute;
                    OpLoad, OpStore:              state_d = StMemAdr;
                    OpBranch:                     state_d = StBranch;
                    OpJal, OpJalr:                state_d = StJump;
                    default: begin
                        bus.PCWrite   = 1'b1;
                        bus.InstrDone = 1'b1;
                        state_d       = StFetch;
                    end
                endcase
            end
            StExecute: state_d = StAluWb;
            StAluWb: begin
                bus.RegWrite  = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            StMemAdr:  state_d = (op_q == OpLoad) ? StMemRead : StMemWrite;
            StMemRead: state_d = StMemWb;
            StMemWb: begin
                bus.ResultSrc = ResMem;
                bus.RegWrite  = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                bus.MemWrite  = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.PCWrite   = 1'b1;
                bus.PCSrc     = taken ? PcTarget : PcPlus4;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = ResPc4;
                bus.PCWrite   = 1'b1;
                bus.PCSrc     = (op_q == OpJalr) ? PcAlu : PcTarget;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
`ifdef ILLEGAL_TRAP_EN
            StHalt: state_d = StHalt;
`endif
            default: state_d = StFetch;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected output timelines from a
// phase-level model, checked every cycle, plus literal pins and reset/trap checks.
module tb_multicycle_ctrl;
    localparam logic [6:0] O_LOAD = 7'h03, O_STORE = 7'h23, O_IMM = 7'h13, O_REG = 7'h33;
    localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_BR = 7'h63;
    localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67;
    localparam logic [3:0] ALU_BY_F3 [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

    typedef struct packed {
        logic       req, irw, pcw;
        logic [1:0] pcsrc;
        logic       regw, memw, asa, asb;
        logic [3:0] aluc;
        logic [1:0] rsrc;
        logic [2:0] imm;
        logic       ls;
        logic [1:0] size;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    string cur = "reset";

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t act_vec();
        vec_t v;
        v.req = bus.InstrReq;     v.irw = bus.IRWrite;     v.pcw = bus.PCWrite;
        v.pcsrc = bus.PCSrc;      v.regw = bus.RegWrite;   v.memw = bus.MemWrite;
        v.asa = bus.ALUSrcA;      v.asb = bus.ALUSrcB;     v.aluc = bus.ALUControl;
        v.rsrc = bus.ResultSrc;   v.imm = bus.ImmSrc;      v.ls = bus.LoadSign;
        v.size = bus.SizeSrc;     v.done = bus.InstrDone;
        return v;
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] op);
        if (op == O_STORE) return 3'd1;
        if (op == O_BR) return 3'd2;
        if (op == O_LUI || op == O_AUIPC) return 3'd3;
        if (op == O_JAL) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] alu_of(logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        if (op == O_REG && ins[30] && f3 == 3'd0) return 4'd1;
        if ((op == O_REG || op == O_IMM) && ins[30] && f3 == 3'd5) return 4'd7;
        if (op == O_REG || op == O_IMM) return ALU_BY_F3[f3];
        if (op == O_LUI) return 4'd10;
        if (op == O_BR) return 4'd1;
        return 4'd0;
    endfunction

    // Expected outputs, one entry per cycle of the instruction (fetch waits included).
    function automatic void push_model(logic [31:0] ins, int waits, bit z, bit sl, bit ul);
        logic [6:0] op;
        logic [2:0] f3;
        vec_t v, dec, dp, mem;
        bit   tk;
        op = ins[6:0];
        f3 = ins[14:12];
        for (int i = 0; i < waits; i++) begin
            v = '0; v.req = 1'b1; exp_q.push_back(v);
        end
        v = '0; v.req = 1'b1; v.irw = 1'b1; exp_q.push_back(v);
        dec = '0; dec.imm = imm_of(op);
        dp = dec; dp.aluc = alu_of(ins);
        dp.asa = (op == O_AUIPC);
        dp.asb = op inside {O_IMM, O_LUI, O_AUIPC, O_LOAD, O_STORE, O_JALR};
        mem = dp; mem.size = f3[1:0]; mem.ls = ~f3[2];
        case (op)
            O_REG, O_IMM, O_LUI, O_AUIPC: begin
                exp_q.push_back(dec); exp_q.push_back(dp);
                v = dp; v.regw = 1; v.pcw = 1; v.done = 1; exp_q.push_back(v);
            end
            O_LOAD: begin
                exp_q.push_back(dec); exp_q.push_back(mem); exp_q.push_back(mem);
                v = mem; v.rsrc = 2'd1; v.regw = 1; v.pcw = 1; v.done = 1; exp_q.push_back(v);
            end
            O_STORE: begin
                exp_q.push_back(dec); exp_q.push_back(mem);
                v = mem; v.memw = 1; v.pcw = 1; v.done = 1; exp_q.push_back(v);
            end
            O_BR: begin
                case (f3)
                    3'd0: tk = z;   3'd1: tk = !z;
                    3'd4: tk = sl;  3'd5: tk = !sl;
                    3'd6: tk = ul;  3'd7: tk = !ul;
                    default: tk = 0;
                endcase
                exp_q.push_back(dec);
                v = dp; v.pcw = 1; v.pcsrc = tk ? 2'd1 : 2'd0; v.done = 1; exp_q.push_back(v);
            end
            O_JAL, O_JALR: begin
                exp_q.push_back(dec);
                v = dp; v.regw = 1; v.rsrc = 2'd2; v.pcw = 1; v.done = 1;
                v.pcsrc = (op == O_JALR) ? 2'd2 : 2'd1;
                exp_q.push_back(v);
            end
            default: begin
                v = dec; v.pcw = 1; v.done = 1; exp_q.push_back(v);
            end
        endcase
    endfunction

    task automatic drive(string name, logic [31:0] ins, int waits, bit z, bit sl, bit ul);
        int n;
        n = exp_q.size();
        cur = name;
        bus.Instr = ins; bus.Zero = z; bus.signedLess = sl; bus.unsignedLess = ul;
        for (int i = 0; i < n; i++) begin
            bus.InstrValid = (i >= waits);
            @(posedge clk); #1;
        end
        bus.InstrValid = 1'b0;
    endtask

    task automatic run(string name, logic [31:0] ins, int waits, bit z, bit sl, bit ul);
        push_model(ins, waits, z, sl, ul);
        drive(name, ins, waits, z, sl, ul);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check(cur, act_vec(), e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.InstrValid = 1'b0; bus.Instr = '0;
        bus.Zero = 1'b0; bus.signedLess = 1'b0; bus.unsignedLess = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = act_vec(); v.req = 1'b0;
        check("reset_outputs", v, 0);
`ifdef ILLEGAL_TRAP_EN
        check("reset_illegal", bus.IllegalInstr, 0);
`endif
        rst_n = 1'b1;

        push_model(32'h002081B3, 0, 0, 0, 0);
        check("pin_add_len", exp_q.size(), 4);
        check("pin_add_wb", {exp_q[3].regw, exp_q[3].pcw, exp_q[3].done, exp_q[3].pcsrc}, 5'b11100);
        drive("add", 32'h002081B3, 0, 0, 0, 0);

        push_model(32'h00409283, 0, 0, 0, 0);
        check("pin_lh_len", exp_q.size(), 5);
        check("pin_lh_wb", {exp_q[4].rsrc, exp_q[4].size, exp_q[4].ls}, 5'b01011);
        drive("lh", 32'h00409283, 0, 0, 0, 0);

        push_model(32'h0040C283, 0, 0, 0, 0);
        check("pin_lbu_wb", {exp_q[4].size, exp_q[4].ls}, 3'b000);
        drive("lbu", 32'h0040C283, 0, 0, 0, 0);

        push_model(32'h00209463, 0, 1, 0, 0);
        check("pin_bne_nt", {exp_q.size() == 3, exp_q[2].pcsrc}, 3'b100);
        drive("bne_z1", 32'h00209463, 0, 1, 0, 0);
        push_model(32'h00209463, 0, 0, 0, 0);
        check("pin_bne_t", exp_q[2].pcsrc, 2'd1);
        drive("bne_z0", 32'h00209463, 0, 0, 0, 0);
        push_model(32'h0020F463, 0, 0, 0, 0);
        check("pin_bgeu_t", exp_q[2].pcsrc, 2'd1);
        drive("bgeu_ul0", 32'h0020F463, 0, 0, 0, 0);
        run("blt_sl1", 32'h0020C463, 0, 0, 1, 0);
        run("bgeu_ul1", 32'h0020F463, 0, 0, 0, 1);

        push_model(32'hFFF00093, 3, 0, 0, 0);
        check("pin_addi_alu", exp_q[5].aluc, 4'd0);
        drive("addi_wait3", 32'hFFF00093, 3, 0, 0, 0);
        push_model(32'h402081B3, 0, 0, 0, 0);
        check("pin_sub_alu", exp_q[2].aluc, 4'd1);
        drive("sub", 32'h402081B3, 0, 0, 0, 0);
        push_model(32'h4030D093, 0, 0, 0, 0);
        check("pin_srai_alu", exp_q[2].aluc, 4'd7);
        drive("srai", 32'h4030D093, 0, 0, 0, 0);
        push_model(32'h123452B7, 0, 0, 0, 0);
        check("pin_lui_alu", exp_q[2].aluc, 4'd10);
        drive("lui", 32'h123452B7, 0, 0, 0, 0);
        run("auipc", 32'h00000297, 1, 0, 0, 0);
        run("jal", 32'h008000EF, 0, 0, 0, 0);
        push_model(32'h000100E7, 0, 0, 0, 0);
        check("pin_jalr_pcsrc", exp_q[2].pcsrc, 2'd2);
        drive("jalr", 32'h000100E7, 0, 0, 0, 0);
        run("sw", 32'h0020A423, 2, 0, 0, 0);

        // Reset asserted mid-store: MemWrite must drop without waiting for a clock edge.
        cur = "sw_reset";
        bus.Instr = 32'h0020A423; bus.InstrValid = 1'b1;
        @(posedge clk); #1;
        bus.InstrValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("memwrite_before_reset", bus.MemWrite, 1);
        #2 rst_n = 1'b0;
        #1;
        check("memwrite_async_drop", bus.MemWrite, 0);
        v = act_vec(); v.req = 1'b0;
        check("reset_mid_outputs", v, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        v = '0; v.req = 1'b1;
        check("after_reset_fetch", act_vec(), v);
        run("add_after_reset", 32'h002081B3, 0, 0, 0, 0);

`ifdef ILLEGAL_TRAP_EN
        cur = "illegal";
        bus.Instr = 32'h0000007F; bus.InstrValid = 1'b1;
        @(posedge clk); #1;
        check("illegal_decode_pcw", bus.PCWrite, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("illegal_flag", bus.IllegalInstr, 1);
            check("illegal_req", bus.InstrReq, 0);
            check("illegal_irwrite", bus.IRWrite, 0);
            @(posedge clk); #1;
        end
        bus.InstrValid = 1'b0;
`else
        push_model(32'h0000007F, 0, 0, 0, 0);
        check("pin_nop", {exp_q.size() == 2, exp_q[1].pcw, exp_q[1].done}, 3'b111);
        drive("nop_7f", 32'h0000007F, 0, 0, 0, 0);
        run("add_after_nop", 32'h002081B3, 0, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
